// File: rtl/ysyx_25040129_ifu_prefetch.sv
// ---------------------------------------------------------------------------
// ysyx_25040129_ifu_prefetch
//
// Prefetching instruction fetch unit. This is a credit-based AXI-lite read
// master that keeps up to MAX_OUTSTANDING reads in flight. Returned
// instructions are buffered in a FIFO_DEPTH-entry queue in front of the IDU.
// A pipeline flush discards every buffered instruction and every response
// that belongs to a request issued before the flush.
//
// Parameters
//   RESET_PC        first fetch address after reset
//   FIFO_DEPTH      instruction queue entries (power of two, >= 2)
//   MAX_OUTSTANDING accepted-but-unanswered reads (1..FIFO_DEPTH)
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   flush             single-cycle flush pulse
//   flush_target      new fetch PC (bits [1:0] are ignored)
//   out_valid/ready   IDU handshake
//   out_pc/inst/fault head instruction, its PC and its fault flag
//   araddr/arvalid/arready        AXI read-address channel
//   rdata/rresp/rvalid/rready     AXI read-data channel
//
// Configuration
//   YSYX_25040129_IFU_FAULT_EN  when defined, each queue entry stores a
//                               fault bit (rresp != OKAY) and drives it on
//                               out_fault. Otherwise out_fault is tied to 0.
// ---------------------------------------------------------------------------
module ysyx_25040129_ifu_prefetch #(
    parameter logic [31:0] RESET_PC        = 32'h3000_0000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned OS_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned AQ_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]      fetch_pc_q,    fetch_pc_d;
    logic [31:0]      stale_addr_q,  stale_addr_d;   // address of an AR held across a flush
    logic             ar_stale_q,    ar_stale_d;
    logic [OS_W-1:0]  outstanding_q, outstanding_d;
    logic [OS_W-1:0]  drop_cnt_q,    drop_cnt_d;
    logic [AQ_W-1:0]  aq_wr_q,       aq_wr_d;
    logic [AQ_W-1:0]  aq_rd_q,       aq_rd_d;
    logic [PTR_W-1:0] wr_ptr_q,      wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
    logic [CNT_W-1:0] fifo_count_q,  fifo_count_d;

    // In-order address queue: the AXI slave answers in order, so the head
    // of this queue is the PC of the response currently on the R channel.
    logic [31:0]      aq_mem        [MAX_OUTSTANDING];
    logic [31:0]      fifo_pc_mem   [FIFO_DEPTH];
    logic [31:0]      fifo_inst_mem [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Handshakes and credit
    // ------------------------------------------------------------------
    logic           ar_hs;
    logic           r_hs;
    logic           r_drop;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_nonempty;
    logic           credit_ok;
    logic [SUM_W-1:0] credit_used;

    // Each accepted read reserves a queue slot until it is answered and
    // popped, so a response never finds the FIFO full.
    assign credit_used = {1'b0, fifo_count_q} + SUM_W'(outstanding_q);
    assign credit_ok   = (outstanding_q < OS_W'(MAX_OUTSTANDING)) &&
                         (credit_used < SUM_W'(FIFO_DEPTH));

    // A stale AR is still presented until the slave takes it; AXI forbids
    // withdrawing arvalid once raised.
    assign arvalid = !rst && (ar_stale_q || credit_ok);
    assign araddr  = ar_stale_q ? stale_addr_q : fetch_pc_q;
    assign rready  = !rst;

    assign ar_hs         = arvalid && arready;
    assign r_hs          = rvalid && rready;
    assign r_drop        = (drop_cnt_q != '0);
    assign fifo_nonempty = (fifo_count_q != '0);
    assign fifo_push     = r_hs && !r_drop && !flush;
    assign out_valid     = fifo_nonempty && !flush;
    assign fifo_pop      = out_valid && out_ready;

    function automatic logic [AQ_W-1:0] aq_inc(input logic [AQ_W-1:0] p);
        if (p == AQ_W'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + AQ_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        fetch_pc_d    = fetch_pc_q;
        stale_addr_d  = stale_addr_q;
        ar_stale_d    = ar_stale_q;
        outstanding_d = outstanding_q + OS_W'(ar_hs) - OS_W'(r_hs);
        drop_cnt_d    = drop_cnt_q;
        aq_wr_d       = aq_wr_q;
        aq_rd_d       = aq_rd_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_count_d  = fifo_count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

        if (ar_hs) begin
            aq_wr_d = aq_inc(aq_wr_q);
        end
        if (r_hs) begin
            aq_rd_d = aq_inc(aq_rd_q);
        end

        // Issue side: a stale AR consumes a credit but must not advance
        // the PC, and its eventual response has to be thrown away.
        if (ar_hs) begin
            if (ar_stale_q) begin
                ar_stale_d = 1'b0;
            end else begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
        end

        if (r_hs && r_drop) begin
            drop_cnt_d = drop_cnt_q - OS_W'(1);
        end
        if (ar_hs && ar_stale_q) begin
            drop_cnt_d = drop_cnt_d + OS_W'(1);
        end

        if (fifo_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Flush overrides everything above. Every read still in flight after
        // this cycle's handshakes predates the flush, so all of them are
        // dropped; a still-pending AR becomes stale and is counted when
        // the slave accepts it.
        if (flush) begin
            fetch_pc_d   = {flush_target[31:2], 2'b00};
            drop_cnt_d   = outstanding_d;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fifo_count_d = '0;
            if (arvalid && !arready) begin
                ar_stale_d   = 1'b1;
                stale_addr_d = araddr;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            stale_addr_q  <= '0;
            ar_stale_q    <= 1'b0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            aq_wr_q       <= '0;
            aq_rd_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_count_q  <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            stale_addr_q  <= stale_addr_d;
            ar_stale_q    <= ar_stale_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            aq_wr_q       <= aq_wr_d;
            aq_rd_q       <= aq_rd_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_count_q  <= fifo_count_d;
        end
    end

    // NOTE: storage arrays are not reset; the pointers and counts qualify
    // every read, so entry contents never matter until written.
    always_ff @(posedge clk) begin
        if (ar_hs) begin
            aq_mem[aq_wr_q] <= araddr;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_pc_mem[wr_ptr_q]   <= aq_mem[aq_rd_q];
            fifo_inst_mem[wr_ptr_q] <= rdata;
        end
    end

    // Head fields read zero while the queue is empty, so reset presents
    // clean outputs even though the storage itself is not cleared.
    assign out_pc   = fifo_nonempty ? fifo_pc_mem[rd_ptr_q]   : '0;
    assign out_inst = fifo_nonempty ? fifo_inst_mem[rd_ptr_q] : '0;

`ifdef YSYX_25040129_IFU_FAULT_EN
    logic fifo_fault_mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_fault_mem[wr_ptr_q] <= (rresp != 2'b00);
        end
    end

    assign out_fault = fifo_nonempty && fifo_fault_mem[rd_ptr_q];
`else
    logic unused_rresp;
    assign unused_rresp = ^rresp;
    assign out_fault    = 1'b0;
`endif

    logic unused_target_lsbs;
    assign unused_target_lsbs = ^flush_target[1:0];

endmodule

// File: tb/tb_ysyx_25040129_ifu_prefetch.sv
// Self-checking bench for ysyx_25040129_ifu_prefetch.
// A bench-side AXI slave answers reads in order with a configurable latency.
// The reference model is transaction level: every accepted read carries the
// flush epoch it was issued in. A response is kept only if its epoch is
// still current, kept responses form an expected instruction queue, and the
// DUT outputs are compared against that model every cycle.
module tb_ysyx_25040129_ifu_prefetch;

    localparam logic [31:0] RESET_PC = 32'h3000_0000;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;
`ifdef YSYX_25040129_IFU_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] flush_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    always #5 clk = ~clk;

    ysyx_25040129_ifu_prefetch #(
        .RESET_PC       (RESET_PC),
        .FIFO_DEPTH     (DEPTH),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .flush_target(flush_target),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_fault   (out_fault),
        .araddr      (araddr),
        .arvalid     (arvalid),
        .arready     (arready),
        .rdata       (rdata),
        .rresp       (rresp),
        .rvalid      (rvalid),
        .rready      (rready)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
        logic [1:0]  resp;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } ent_t;

    int checks = 0;
    int errors = 0;
    int cycle;

    // Stimulus knobs (percent probabilities, latency range)
    int ar_pct, r_pct, rdy_pct, lat_min, lat_max, flush_pct;
    bit fault_dir;

    // Model state
    req_t        sq[$];       // reads accepted by the slave, not yet answered
    ent_t        mq[$];       // instructions the IDU must still receive
    logic [31:0] m_pc;
    bit          m_stale;
    logic [31:0] m_stale_addr;
    int          m_epoch;

    // Logs of what the DUT actually did, for literal spot checks
    logic [31:0] delivered[$];
    int          dcyc[$];
    logic        dfault[$];
    logic [31:0] ar_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", name, act, exp, cycle, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'h0F0F};
    endfunction

    function automatic logic [1:0] pick_resp(input logic [31:0] a);
        if (fault_dir) return (a == 32'h3000_0004) ? 2'b10 : 2'b00;
        if ($urandom_range(7) == 0) return 2'($urandom_range(3, 1));
        return 2'b00;
    endfunction

    function automatic int pick_lat();
        return int'($urandom_range(lat_max, lat_min));
    endfunction

    function automatic logic [31:0] dget(input int i);
        if (i < delivered.size()) return delivered[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] aget(input int i);
        if (i < ar_log.size()) return ar_log[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] cget(input int i);
        if (i < dcyc.size()) return 32'(dcyc[i]);
        return 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] fget(input int i);
        if (i < dfault.size()) return 32'(dfault[i]);
        return 32'hxxxx_xxxx;
    endfunction

    task automatic do_reset();
        rst          = 1'b1;
        flush        = 1'b0;
        flush_target = '0;
        arready      = 1'b0;
        rvalid       = 1'b0;
        rdata        = '0;
        rresp        = 2'b00;
        out_ready    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_arvalid",   32'(arvalid),   32'd0);
        check("rst_rready",    32'(rready),    32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc",    out_pc,         32'd0);
        check("rst_out_inst",  out_inst,       32'd0);
        check("rst_out_fault", 32'(out_fault), 32'd0);
        check("rst_araddr",    araddr,         RESET_PC);
        sq.delete();
        mq.delete();
        delivered.delete();
        dcyc.delete();
        dfault.delete();
        ar_log.delete();
        m_pc         = RESET_PC;
        m_stale      = 1'b0;
        m_stale_addr = '0;
        m_epoch      = 0;
        cycle        = 0;
        rst          = 1'b0;
        #1;
        check("post_rst_arvalid", 32'(arvalid), 32'd1);
        check("post_rst_araddr",  araddr,       RESET_PC);
    endtask

    // One clock cycle: drive inputs after the falling edge, compare outputs
    // against the model, then advance the model across the next rising edge.
    task automatic tick(input bit fl, input logic [31:0] tgt);
        bit          ar_hs, r_hs, pop, exp_arv, exp_ov;
        logic [31:0] exp_addr;
        int          new_epoch;
        req_t        rq;
        ent_t        e;

        @(negedge clk);
        flush        = fl;
        flush_target = tgt;
        arready      = ($urandom_range(99) < ar_pct);
        out_ready    = ($urandom_range(99) < rdy_pct);
        if (sq.size() > 0 && sq[0].due <= cycle && $urandom_range(99) < r_pct) begin
            rvalid = 1'b1;
            rdata  = inst_of(sq[0].addr);
            rresp  = sq[0].resp;
        end else begin
            rvalid = 1'b0;
            rdata  = $urandom;
            rresp  = 2'($urandom_range(3));
        end
        #1;

        exp_arv  = m_stale || (sq.size() < MAXO && sq.size() + mq.size() < DEPTH);
        exp_addr = m_stale ? m_stale_addr : m_pc;
        check("arvalid", 32'(arvalid), 32'(exp_arv));
        if (exp_arv) check("araddr", araddr, exp_addr);
        check("rready", 32'(rready), 32'd1);
        exp_ov = (mq.size() > 0) && !fl;
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            check("out_pc",    out_pc,           mq[0].pc);
            check("out_inst",  out_inst,         mq[0].inst);
            check("out_fault", 32'(out_fault),   32'(mq[0].fault));
        end

        ar_hs     = arvalid && arready;
        r_hs      = rvalid && rready;
        pop       = out_valid && out_ready;
        new_epoch = m_epoch + (fl ? 1 : 0);

        if (pop && mq.size() > 0) begin
            e = mq.pop_front();
            delivered.push_back(out_pc);
            dcyc.push_back(cycle);
            dfault.push_back(out_fault);
        end
        if (r_hs && sq.size() > 0) begin
            rq = sq.pop_front();
            if (rq.epoch == new_epoch) begin
                e.pc    = rq.addr;
                e.inst  = inst_of(rq.addr);
                e.fault = FAULT_EN && (rq.resp != 2'b00);
                mq.push_back(e);
            end
        end
        if (ar_hs) begin
            ar_log.push_back(araddr);
            if (m_stale) begin
                rq = '{m_stale_addr, -1, cycle + pick_lat(), pick_resp(m_stale_addr)};
                sq.push_back(rq);
                m_stale = 1'b0;
            end else begin
                rq = '{m_pc, m_epoch, cycle + pick_lat(), pick_resp(m_pc)};
                sq.push_back(rq);
                m_pc = m_pc + 32'd4;
            end
        end
        if (fl) begin
            mq.delete();
            if (exp_arv && !arready && !m_stale) begin
                m_stale      = 1'b1;
                m_stale_addr = exp_addr;
            end
            m_pc    = {tgt[31:2], 2'b00};
            m_epoch = new_epoch;
        end
        cycle++;
    endtask

    task automatic set_knobs(input int ar, input int r, input int rdy, input int lmin, input int lmax);
        ar_pct  = ar;
        r_pct   = r;
        rdy_pct = rdy;
        lat_min = lmin;
        lat_max = lmax;
    endtask

    initial begin
        bit          fl;
        logic [31:0] tgt;
        fault_dir = 1'b0;
        flush_pct = 0;
        set_knobs(100, 100, 100, 1, 1);

        // Zero-wait slave, IDU always ready: back-to-back delivery.
        do_reset();
        repeat (8) tick(1'b0, '0);
        check("zw_pc0",  dget(0), 32'h3000_0000);
        check("zw_pc1",  dget(1), 32'h3000_0004);
        check("zw_pc2",  dget(2), 32'h3000_0008);
        check("zw_cyc0", cget(0), 32'd2);
        check("zw_cyc1", cget(1), 32'd3);
        check("zw_cyc2", cget(2), 32'd4);

        // IDU stalled: issue stops once outstanding + count reaches DEPTH.
        do_reset();
        set_knobs(100, 100, 0, 1, 1);
        repeat (10) tick(1'b0, '0);
        check("bp_ar_count",   32'(ar_log.size()), 32'd4);
        check("bp_arvalid_lo", 32'(arvalid),       32'd0);
        rdy_pct = 100;
        repeat (8) tick(1'b0, '0);
        check("bp_pc0",    dget(0), 32'h3000_0000);
        check("bp_pc1",    dget(1), 32'h3000_0004);
        check("bp_pc2",    dget(2), 32'h3000_0008);
        check("bp_pc3",    dget(3), 32'h3000_000C);
        check("bp_resume", 32'(ar_log.size() > 4), 32'd1);

        // Three-cycle slave, two reads in flight, then flush.
        do_reset();
        set_knobs(100, 100, 100, 3, 3);
        repeat (2) tick(1'b0, '0);
        tick(1'b1, 32'h8000_0100);
        repeat (12) tick(1'b0, '0);
        check("fl_ar2", aget(2), 32'h8000_0100);
        check("fl_pc0", dget(0), 32'h8000_0100);

        // AR held across a flush: stays at the old address, gets dropped.
        do_reset();
        set_knobs(0, 100, 100, 1, 1);
        tick(1'b0, '0);
        tick(1'b1, 32'h8000_0200);
        repeat (2) tick(1'b0, '0);
        check("st_hold_addr", araddr,         32'h3000_0000);
        check("st_hold_vld",  32'(arvalid),   32'd1);
        ar_pct = 100;
        repeat (10) tick(1'b0, '0);
        check("st_ar0", aget(0), 32'h3000_0000);
        check("st_ar1", aget(1), 32'h8000_0200);
        check("st_pc0", dget(0), 32'h8000_0200);

        // Flush in the same cycle as an R handshake; target LSBs ignored.
        do_reset();
        set_knobs(100, 100, 100, 1, 1);
        tick(1'b0, '0);
        tick(1'b1, 32'h8000_0303);
        repeat (10) tick(1'b0, '0);
        check("fr_ar2", aget(2), 32'h8000_0300);
        check("fr_pc0", dget(0), 32'h8000_0300);

        // Error response on the second fetch.
        fault_dir = 1'b1;
        do_reset();
        repeat (8) tick(1'b0, '0);
        check("ft_pc1", dget(1), 32'h3000_0004);
        check("ft_f0",  fget(0), 32'd0);
        check("ft_f1",  fget(1), 32'(FAULT_EN));
        check("ft_f2",  fget(2), 32'd0);
        fault_dir = 1'b0;

        // Randomized traffic with flushes, PC wrap and mid-flight resets.
        for (int seg = 0; seg < 20; seg++) begin
            if (seg % 6 == 0) do_reset();
            set_knobs(int'($urandom_range(100, 20)), int'($urandom_range(100, 20)),
                      int'($urandom_range(100, 10)), 1, int'($urandom_range(6, 1)));
            flush_pct = int'($urandom_range(8, 0));
            for (int k = 0; k < 150; k++) begin
                fl  = ($urandom_range(99) < flush_pct);
                tgt = ($urandom_range(9) == 0) ? (32'hFFFF_FFF4 | 32'($urandom_range(3))) : $urandom;
                tick(fl, tgt);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25040129_ifu_prefetch.md
# ysyx_25040129_ifu_prefetch

Parametrised prefetching instruction fetch unit. It replaces the single-request fetch FSM with a credit-based AXI-lite read master that allows up to `MAX_OUTSTANDING` in-flight reads. Fetched instructions are buffered in a `FIFO_DEPTH`-entry queue ahead of the IDU. It sits between the core's IDU handshake and the instruction-side AXI read channel, and on a pipeline flush it discards every stale request and buffered instruction.

## Interface
Parameters:
- `RESET_PC`, 32'h3000_0000: first fetch address after reset.
- `FIFO_DEPTH`, 4: instruction queue entries; power of two, ≥2.
- `MAX_OUTSTANDING`, 2: maximum accepted-but-unanswered reads; 1..`FIFO_DEPTH`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: pipeline flush request, single-cycle pulse.
- `flush_target` in 32: new fetch PC; bits [1:0] are ignored and treated as 0.
- `out_valid` out 1: instruction available to the IDU.
- `out_ready` in 1: IDU accepts the instruction.
- `out_pc` out 32: PC of the head instruction.
- `out_inst` out 32: head instruction.
- `out_fault` out 1: head fetch returned a non-OKAY `rresp`.
- `araddr` out 32: AR address.
- `arvalid` out 1: AR valid.
- `arready` in 1: AR ready.
- `rdata` in 32: R data.
- `rresp` in 2: R response.
- `rvalid` in 1: R valid.
- `rready` out 1: R ready.

## Operation
Fetch PC and issue:
- `fetch_pc` is reset to `RESET_PC`.
- `arvalid` is asserted when both conditions hold: `outstanding` < `MAX_OUTSTANDING`, and `outstanding` + `fifo_count` < `FIFO_DEPTH`.
- `araddr` = `fetch_pc`.
- On an AR handshake: `fetch_pc` += 4, `outstanding` += 1, and the address is pushed into the in-order address queue (depth `MAX_OUTSTANDING`).
- Once `arvalid` is high without `arready`, `araddr` and `arvalid` hold stable until the handshake. Flush does not withdraw the request.

Response path:
- `rready` = 1 whenever not in reset. Credit accounting guarantees FIFO space.
- On an R handshake: `outstanding` -= 1 and the address queue pops.
- If `drop_cnt` > 0, the response is discarded and `drop_cnt` -= 1.
- Otherwise `{addr, rdata, fault}` is pushed into the FIFO.

Output:
- `out_valid` = FIFO non-empty && !`flush`.
- Head fields are driven from the FIFO read pointer.
- A pop happens on `out_valid && out_ready`.

Flush, on the clock edge where `flush` = 1:
- The FIFO is cleared (pointers and count reset).
- `drop_cnt` <= `outstanding` after this cycle's AR/R handshakes, so a response handshaked in the flush cycle is itself dropped.
- If an AR is pending and not accepted, the `ar_stale` flag is set. When that AR is later accepted, `drop_cnt` increments and `fetch_pc` is not advanced.
- `fetch_pc` <= `{flush_target[31:2], 2'b00}`. New issue is suppressed while `ar_stale` = 1.

Simultaneous events:
- Flush together with `out_ready`: flush wins and no pop is counted.
- Push and pop in the same cycle: `fifo_count` is unchanged.
- A second flush while `drop_cnt` > 0 recomputes `drop_cnt` from the current `outstanding`.

Wrap-around:
- FIFO pointers are log2(`FIFO_DEPTH`) bits wide and wrap naturally.
- `fetch_pc` wraps modulo 2^32.

Reset:
- `rst` mid-transaction clears all state: `outstanding`, `drop_cnt`, FIFO, `ar_stale`.
- The AXI slave is also reset in the system, so no responses are tracked across reset.

## Timing
Reset values:
- `arvalid` = 0, `rready` = 0, `out_valid` = 0.
- `out_pc`, `out_inst`, `out_fault` = 0.
- `araddr` = `RESET_PC`.

Latency and throughput:
- The first cycle after `rst` deasserts has `arvalid` = 1 with `araddr` = `RESET_PC`.
- An R handshake at edge N gives `out_valid` = 1 in cycle N+1. There is no combinational rdata→out bypass.
- Sustained throughput is 1 instruction/cycle when the slave returns one response per cycle, `MAX_OUTSTANDING` ≥ 2, and the IDU is always ready.
- After a flush at edge N, `out_valid` is 0 from cycle N+1 until the first post-flush response has been written.

## Configuration
`YSYX_25040129_IFU_FAULT_EN`:
- Defined: the FIFO stores a fault bit per entry, set when `rresp` != 2'b00. `out_fault` reflects the head entry, and the instruction is still delivered.
- Undefined: `rresp` is ignored, no fault storage is instantiated, and `out_fault` is tied to 0.

## Test plan
- Reset, then a zero-wait slave (`arready` = `rvalid` = 1) with `out_ready` = 1: PCs 0x3000_0000, 0x3000_0004, 0x3000_0008 appear on consecutive cycles.
- `out_ready` = 0 for 10 cycles with `FIFO_DEPTH` = 4: `arvalid` drops once outstanding + count = 4. The FIFO holds 4 entries in order with no loss, and draining resumes issue.
- Slave with 3-cycle read latency, 2 reads outstanding, flush to 0x8000_0100: both stale responses are dropped, and the next `out_pc` is 0x8000_0100.
- `arvalid` held with `arready` = 0, flush to 0x8000_0200, then `arready` after 2 cycles: `araddr` stays at the old PC until accepted, its response is dropped, and the next AR is 0x8000_0200.
- Flush and R handshake in the same cycle, with `flush_target` = 0x8000_0303: the response is dropped, and fetch restarts at 0x8000_0300.
- With `_FAULT_EN` defined, `rresp` = 2'b10 on the second fetch: `out_fault` = 1 only with `out_pc` = 0x3000_0004. Without the macro, `out_fault` stays 0.
